serial_word_tx: RTL

Parallel-to-serial transmitter that drives a generated serial clock, data line and frame strobe. Downstream, a positive-edge D flip-flop shift chain captures the stream. Sits between a parallel producer, such as switches or a counter, and the serial capture side of a lab board design. It uses a valid/ready load handshake and sends MSB first.

---
 rtl/serial_pkg.sv | 22 ++
 rtl/serial_half_timer.sv | 40 ++++
 rtl/serial_word_tx.sv | 134 +++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
//==============================================================================
// Module      : serial_pkg
// Description : Shared constants for the serial word transmitter and the
//               matching receiver: FSM state encoding and default sizing.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package serial_pkg;

  // Transmitter FSM state encoding
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_SHIFT = 2'd1;
  localparam logic [1:0] TX_GAP   = 2'd2;

  // Default word size and serial clock divider, shared by TX and RX
  localparam int SER_WIDTH_DEFAULT = 8;
  localparam int SER_DIV_DEFAULT   = 4;

endpackage

`default_nettype wire

// File: rtl/serial_half_timer.sv
//==============================================================================
// Module      : serial_half_timer
// Description : Loadable down-counter spanning DIV clock cycles. Tc is high
//               in the last cycle of the span (count at zero). Once expired
//               the counter parks at zero until it is loaded again.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_half_timer #(
  parameter int DIV = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Load,
  output logic Tc
);

  localparam int                 c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_LOAD  = c_CNT_W'(DIV - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_cnt;

  // Reload on request, otherwise count down and hold at zero
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (Load) begin
      r_cnt <= c_LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - c_ONE;
    end
  end

  assign Tc = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/serial_word_tx.sv
//==============================================================================
// Module      : serial_word_tx
// Description : Parallel-to-serial transmitter. Accepts a word on a
//               Valid/Ready handshake and sends it MSB first with a generated
//               serial clock (data stable across the SerClk rising edge), a
//               frame strobe over the data phase, a DIV-cycle gap and a
//               one-cycle Done pulse. All outputs are registered.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_word_tx
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEFAULT,
  parameter int DIV   = SER_DIV_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Data,
  input  logic             Valid,
  output logic             Ready,
  output logic             SerClk,
  output logic             SerData,
  output logic             SerFrame,
  output logic             Done
);

  localparam int                 c_BIT_W    = $clog2(WIDTH + 1);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(WIDTH - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [c_BIT_W-1:0] r_bit;
  logic               r_ready;
  logic               r_serclk;
  logic               r_serdata;
  logic               r_frame;
  logic               r_done;

  logic               w_tc;
  logic               w_accept;
  logic               w_timer_load;
  logic [WIDTH-1:0]   w_shift_next;

  // Handshake only while idle; the timer restarts on every half-period end
  assign w_accept     = (r_state == TX_IDLE) && Valid;
  assign w_timer_load = w_accept || ((r_state != TX_IDLE) && w_tc);
  assign w_shift_next = r_shift << 1;

  serial_half_timer #(
    .DIV (DIV)
  ) u_half_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .Load  (w_timer_load),
    .Tc    (w_tc)
  );

  // Transmit FSM: load, shift out one bit per two half-periods, gap, done
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= TX_IDLE;
      r_shift   <= '0;
      r_bit     <= '0;
      r_ready   <= 1'b1;
      r_serclk  <= 1'b0;
      r_serdata <= 1'b0;
      r_frame   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          if (Valid) begin
            r_state   <= TX_SHIFT;
            r_shift   <= Data;
            r_bit     <= '0;
            r_ready   <= 1'b0;
            r_frame   <= 1'b1;
            r_serclk  <= 1'b0;
            r_serdata <= Data[WIDTH-1];
          end
        end
        TX_SHIFT: begin
          if (w_tc) begin
            if (!r_serclk) begin
              // Mid-bit: raise the serial clock, data already stable
              r_serclk <= 1'b1;
            end else if (r_bit == c_LAST_BIT) begin
              // End of last bit: drop everything and enter the gap
              r_serclk  <= 1'b0;
              r_serdata <= 1'b0;
              r_frame   <= 1'b0;
              r_shift   <= '0;
              r_bit     <= '0;
              r_state   <= TX_GAP;
            end else begin
              // Bit boundary: clock low and present the next bit together
              r_serclk  <= 1'b0;
              r_shift   <= w_shift_next;
              r_serdata <= w_shift_next[WIDTH-1];
              r_bit     <= r_bit + c_BIT_ONE;
            end
          end
        end
        TX_GAP: begin
          if (w_tc) begin
            r_state <= TX_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state   <= TX_IDLE;
          r_ready   <= 1'b1;
          r_serclk  <= 1'b0;
          r_serdata <= 1'b0;
          r_frame   <= 1'b0;
        end
      endcase
    end
  end

  assign Ready    = r_ready;
  assign SerClk   = r_serclk;
  assign SerData  = r_serdata;
  assign SerFrame = r_frame;
  assign Done     = r_done;

endmodule

`default_nettype wire
